// File: rtl/merge_mem_pkg.sv
// Shared types and constants for the merge_mem sorted-merge engine.
package merge_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

endpackage

// File: rtl/merge_mem_if.sv
// Bus bundle for merge_mem: memory write port, merge control and output stream.
interface merge_mem_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic             wr_sel;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW:0]      len1;
  logic [AW:0]      len2;
  logic             desc;
  logic             start;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic [AW+1:0]    out_cnt;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, len1, len2, desc, start, out_ready,
    input  busy, done, out_valid, out_data, out_src, out_cnt
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, len1, len2, desc, start, out_ready,
    output busy, done, out_valid, out_data, out_src, out_cnt
  );
endinterface

// File: rtl/merge_mem_sel.sv
// merge_sel: combinational head compare; picks the channel supplying the next element.
module merge_sel
  import merge_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] head1,
  input  logic [WIDTH-1:0] head2,
  input  logic             rem1,
  input  logic             rem2,
  input  logic             desc,
  output logic             sel,
  output logic             take
);
  logic ch1_wins;

  // Ties go to ch1 in both orders so equal keys keep their channel order.
  assign ch1_wins = desc ? (head1 >= head2) : (head1 <= head2);
  assign take     = rem1 | rem2;

  always_comb begin
    sel = CH1;
    if (rem1 && rem2) sel = ch1_wins ? CH1 : CH2;
    else if (rem2)    sel = CH2;
  end
endmodule

// File: rtl/merge_mem.sv
// merge_mem: merges two pre-sorted channel memories into one ordered valid/ready stream.
//
// state    | meaning
// ST_IDLE  | waiting for start; memory writes accepted
// ST_MERGE | streaming merged elements
// ST_DONE  | one-cycle completion pulse, busy still high
module merge_mem
  import merge_mem_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  merge_mem_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [WIDTH-1:0] mem2 [DEPTH];
  logic [AW:0]      len1_q, len2_q, p1, p2;
  logic             desc_q;
  logic             rem1, rem2, sel, take, load, accept, room;
  logic [WIDTH-1:0] head1, head2;
  logic             out_valid_q, out_src_q;
  logic [WIDTH-1:0] out_data_q;
  logic [AW+1:0]    out_cnt_q;

  assign rem1  = p1 < len1_q;
  assign rem2  = p2 < len2_q;
  assign head1 = mem1[p1[AW-1:0]];
  assign head2 = mem2[p2[AW-1:0]];
  assign room  = !out_valid_q || bus.out_ready;

  merge_sel #(.WIDTH(WIDTH)) u_sel (
    .head1 (head1),
    .head2 (head2),
    .rem1  (rem1),
    .rem2  (rem2),
    .desc  (desc_q),
    .sel   (sel),
    .take  (take)
  );

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.wr_en) begin
      if (bus.wr_sel == CH1) mem1[bus.wr_addr] <= bus.wr_data;
      else                   mem2[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_MERGE;
      ST_MERGE: begin
        accept = out_valid_q && bus.out_ready;
        load   = take && room;
        if (!take && room) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len1_q      <= '0;
      len2_q      <= '0;
      desc_q      <= 1'b0;
      p1          <= '0;
      p2          <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= CH1;
      out_cnt_q   <= '0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        len1_q    <= (bus.len1 > LEN_MAX) ? LEN_MAX : bus.len1;
        len2_q    <= (bus.len2 > LEN_MAX) ? LEN_MAX : bus.len2;
        desc_q    <= bus.desc;
        p1        <= '0;
        p2        <= '0;
        out_cnt_q <= '0;
      end
      if (accept) out_cnt_q <= out_cnt_q + (AW+2)'(1);
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= (sel == CH1) ? head1 : head2;
        out_src_q   <= sel;
        if (sel == CH1) p1 <= p1 + (AW+1)'(1);
        else            p2 <= p2 + (AW+1)'(1);
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_cnt   = out_cnt_q;
endmodule

// File: tb/tb_merge_mem.sv
// Scoreboard bench for merge_mem: expected {src,data} queued per merge, popped on each handshake.
module tb_merge_mem;
  import merge_mem_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [8:0] exp_q[$];

  merge_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  merge_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 8'(data);
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic push(input logic src, input int data);
    exp_q.push_back({src, 8'(data)});
  endtask

  task automatic load_case1();
    wr(CH1, 0, 1); wr(CH1, 1, 4); wr(CH1, 2, 7); wr(CH1, 3, 9);
    wr(CH2, 0, 2); wr(CH2, 1, 3); wr(CH2, 2, 8);
  endtask

  task automatic push_case1();
    push(CH1, 1); push(CH2, 2); push(CH2, 3); push(CH1, 4);
    push(CH1, 7); push(CH2, 8); push(CH1, 9);
  endtask

  // exp_done is the cycle offset after the start edge at which done must be seen.
  task automatic run(input int l1, input int l2, input logic dsc, input int exp_done,
                     input bit bp, input bit poke);
    int n_exp;
    bit stall;
    bit seen;
    logic [8:0] held;
    logic [8:0] e;
    n_exp = exp_q.size();
    stall = 0;
    seen  = 0;
    held  = '0;
    @(negedge clk);
    bus.len1      = 5'(l1);
    bus.len2      = 5'(l2);
    bus.desc      = dsc;
    bus.start     = 1'b1;
    bus.out_ready = !bp;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_rise", 32'(bus.busy), 32'd1);
      if (poke && i == 4) begin
        bus.start = 1'b1; bus.len1 = 5'd0; bus.len2 = 5'd0;
        bus.wr_en = 1'b1; bus.wr_sel = CH1; bus.wr_addr = 4'd0; bus.wr_data = 8'hff;
      end
      if (poke && i == 5) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      bus.out_ready = bp ? ((i % 2) == 1) : 1'b1;
      if (stall) check("stall_hold", 32'({bus.out_src, bus.out_data}), 32'(held));
      stall = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 32'({bus.out_src, bus.out_data}), 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("elem", 32'({bus.out_src, bus.out_data}), 32'(e));
        end
      end else if (bus.out_valid) begin
        stall = 1;
        held  = {bus.out_src, bus.out_data};
      end
      if (bus.done) begin
        seen = 1;
        check("done_cycle", 32'(i), 32'(exp_done));
        check("out_cnt", 32'(bus.out_cnt), 32'(n_exp));
        check("busy_at_done", 32'(bus.busy), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
      end
    end
    if (!seen) check("done_timeout", 32'(bus.done), 32'd1);
    exp_q.delete();
    @(negedge clk);
    check("idle_after", 32'(bus.busy), 32'd0);
    bus.out_ready = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_done"},  32'(bus.done),      32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_src"},   32'(bus.out_src),   32'd0);
    check({tag, "_cnt"},   32'(bus.out_cnt),   32'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.len1 = 5'd4; bus.len2 = 5'd3; bus.desc = 1'b0; bus.start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) check("pre_reset_cnt", 32'(bus.out_cnt), 32'd2);
      if (i == 5) reset = 1'b0;
    end
    @(negedge clk);
    check_reset_state("mid_reset");
    reset = 1'b1;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len1 = '0; bus.len2 = '0; bus.desc = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;

    load_case1();
    push_case1();
    run(4, 3, 1'b0, 9, 1'b0, 1'b0);

    push_case1();
    run(4, 3, 1'b0, 16, 1'b1, 1'b0);

    push_case1();
    run(4, 3, 1'b0, 9, 1'b0, 1'b1);

    reset_mid();
    push_case1();
    run(4, 3, 1'b0, 9, 1'b0, 1'b0);

    wr(CH1, 0, 5); wr(CH1, 1, 5); wr(CH2, 0, 5);
    push(CH1, 5); push(CH1, 5); push(CH2, 5);
    run(2, 1, 1'b0, 5, 1'b0, 1'b0);

    wr(CH1, 0, 9); wr(CH1, 1, 6); wr(CH1, 2, 2);
    wr(CH2, 0, 8); wr(CH2, 1, 7);
    push(CH1, 9); push(CH2, 8); push(CH2, 7); push(CH1, 6); push(CH1, 2);
    run(3, 2, 1'b1, 7, 1'b0, 1'b0);

    wr(CH2, 0, 30); wr(CH2, 1, 10); wr(CH2, 2, 20);
    push(CH2, 30); push(CH2, 10); push(CH2, 20);
    run(0, 3, 1'b0, 5, 1'b0, 1'b0);

    run(0, 0, 1'b0, 2, 1'b0, 1'b0);

    for (int k = 0; k < DEPTH; k++) wr(CH1, k, 3 * k + 1);
    for (int k = 0; k < DEPTH; k++) push(CH1, 3 * k + 1);
    run(20, 0, 1'b0, 18, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
